// File: rtl/prio_interrupt_controller_if.sv
// Memory-bus port shared by the core and its peripherals.
// The core drives the request side (master). Peripherals answer with read data and ready (slave).
interface mem_if;
  typedef logic [31:0] word_t;

  logic  valid;
  logic  w_en;
  word_t addr;
  word_t w_data;
  word_t r_data;
  logic  ready;

  modport master (
    output valid, w_en, addr, w_data,
    input  r_data, ready
  );

  modport slave (
    input  valid, w_en, addr, w_data,
    output r_data, ready
  );
endinterface

// File: rtl/prio_interrupt_controller.sv
// Prioritised interrupt controller on the core memory bus.
// Per source it provides:
//   - an enable bit
//   - a priority
//   - level or rising-edge triggering
// The core picks up work through a claim/complete handshake, and a source stays
// masked while it is in service.
module prio_interrupt_controller #(
  parameter int NUM_INT_SRCS = 8,
  parameter int PRIO_BITS    = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_INT_SRCS-1:0] i_int,
  output logic                    o_int,
  mem_if.slave                    if_mem
);

  if (NUM_INT_SRCS < 1 || NUM_INT_SRCS > 31) begin : g_bad_num_int_srcs
    $error("prio_interrupt_controller: NUM_INT_SRCS must be in 1..31");
  end
  if (PRIO_BITS < 1 || PRIO_BITS > 8) begin : g_bad_prio_bits
    $error("prio_interrupt_controller: PRIO_BITS must be in 1..8");
  end

  typedef logic [31:0]             word_t;
  typedef logic [PRIO_BITS-1:0]    prio_t;
  typedef logic [NUM_INT_SRCS-1:0] src_vec_t;

  // Word index of each register, taken from addr[7:2].
  typedef enum logic [5:0] {
    REG_ENABLE     = 6'h00,
    REG_PENDING    = 6'h01,
    REG_TRIGGER    = 6'h02,
    REG_THRESHOLD  = 6'h03,
    REG_CLAIM      = 6'h04,
    REG_IN_SERVICE = 6'h05
  } reg_idx_e;

  // PRIORITY[i] sits at word index 0x10 + i (byte address 0x40 + 4*i).
  localparam logic [5:0] PRIO_BASE = 6'h10;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  src_vec_t enable_q;
  src_vec_t pending_q;
  src_vec_t trigger_q;     // 1 = rising-edge, 0 = level
  src_vec_t in_service_q;
  src_vec_t int_q;         // previous i_int, for edge detection
  prio_t    threshold_q;
  prio_t    prio_q [NUM_INT_SRCS];
  word_t    r_data_q;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [5:0] reg_idx;
  logic       rd_en;
  logic       wr_en;
  logic       unused_addr_bits;

  assign reg_idx          = if_mem.addr[7:2];
  assign rd_en            = if_mem.valid & ~if_mem.w_en;
  assign wr_en            = if_mem.valid &  if_mem.w_en;
  // Only addr[7:2] selects a register; the remaining address bits are don't-care.
  assign unused_addr_bits = ^{if_mem.addr[31:8], if_mem.addr[1:0]};

  assign if_mem.ready  = 1'b1;
  assign if_mem.r_data = r_data_q;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration (registered state only, so o_int has no path
  // from i_int or the bus)
  // ---------------------------------------------------------------------------
  src_vec_t   eligible;
  prio_t      best_prio;
  logic [5:0] claim_id;

  // A source may interrupt when enabled, pending, not in service and above threshold.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    eligible = '0;
    for (int i = 0; i < NUM_INT_SRCS; i++) begin
      eligible[i] = enable_q[i] & pending_q[i] & ~in_service_q[i]
                  & (prio_q[i] > threshold_q);
    end
  end

  // Highest priority wins. The strict '>' keeps the lowest index on a tie.
  always_comb begin
    best_prio = '0;
    claim_id  = '0;
    for (int i = 0; i < NUM_INT_SRCS; i++) begin
      if (eligible[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        claim_id  = 6'(i + 1);
      end
    end
  end

  assign o_int = |eligible;

  // ---------------------------------------------------------------------------
  // Claim / complete / clear strobes
  // ---------------------------------------------------------------------------
  logic     claim_take;
  logic     complete_wr;
  logic     pending_wr;
  src_vec_t claim_set;
  src_vec_t complete_clr;
  src_vec_t w1c_clr;
  src_vec_t prio_wr;

  assign claim_take  = rd_en && (reg_idx == REG_CLAIM) && (claim_id != '0);
  assign complete_wr = wr_en && (reg_idx == REG_CLAIM);
  assign pending_wr  = wr_en && (reg_idx == REG_PENDING);
  assign w1c_clr     = pending_wr ? if_mem.w_data[NUM_INT_SRCS-1:0] : '0;

  // Decode the claimed ID, the completed ID and the PRIORITY write target as one-hot vectors.
  // A completion whose ID is 0 or above NUM_INT_SRCS matches no bit and is ignored.
  always_comb begin
    claim_set    = '0;
    complete_clr = '0;
    prio_wr      = '0;
    for (int i = 0; i < NUM_INT_SRCS; i++) begin
      claim_set[i]    = claim_take  && (claim_id == 6'(i + 1));
      complete_clr[i] = complete_wr && (if_mem.w_data == word_t'(i + 1));
      prio_wr[i]      = wr_en       && (reg_idx == PRIO_BASE + 6'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Next pending / in-service state
  // ---------------------------------------------------------------------------
  src_vec_t pending_d;
  src_vec_t in_service_d;

  // Edge sources latch a fresh rising edge. A set in the same cycle as a claim or W1C clear wins.
  // Level sources simply follow the line.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_INT_SRCS; i++) begin
      if (trigger_q[i]) begin
        pending_d[i] = (pending_q[i] & ~(w1c_clr[i] | claim_set[i]))
                     | (i_int[i] & ~int_q[i]);
      end else begin
        pending_d[i] = i_int[i];
      end
    end
  end

  // A single beat is either a read (claim) or a write (complete), never both.
  assign in_service_d = (in_service_q | claim_set) & ~complete_clr;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  word_t rd_mux;

  // Unmapped words and unused upper bits read as 0.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_ENABLE:     rd_mux[NUM_INT_SRCS-1:0] = enable_q;
      REG_PENDING:    rd_mux[NUM_INT_SRCS-1:0] = pending_q;
      REG_TRIGGER:    rd_mux[NUM_INT_SRCS-1:0] = trigger_q;
      REG_THRESHOLD:  rd_mux[PRIO_BITS-1:0]    = threshold_q;
      REG_CLAIM:      rd_mux[5:0]              = claim_id;
      REG_IN_SERVICE: rd_mux[NUM_INT_SRCS-1:0] = in_service_q;
      default: begin
        for (int i = 0; i < NUM_INT_SRCS; i++) begin
          if (reg_idx == PRIO_BASE + 6'(i)) rd_mux[PRIO_BITS-1:0] = prio_q[i];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control registers, interrupt state and read data. A reset discards any concurrent access.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      enable_q     <= '0;
      pending_q    <= '0;
      trigger_q    <= '0;
      in_service_q <= '0;
      int_q        <= '0;
      threshold_q  <= '0;
      r_data_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      int_q        <= i_int;
      if (rd_en) r_data_q <= rd_mux;
      if (wr_en) begin
        case (reg_idx)
          REG_ENABLE:    enable_q    <= if_mem.w_data[NUM_INT_SRCS-1:0];
          REG_TRIGGER:   trigger_q   <= if_mem.w_data[PRIO_BITS > 0 ? NUM_INT_SRCS-1 : 0:0];
          REG_THRESHOLD: threshold_q <= if_mem.w_data[PRIO_BITS-1:0];
          default: ;
        endcase
      end
    end
  end

  // Per-source priority fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the priority array is a small bank of flops, not a RAM. It is
      // reset explicitly so a priority never comes up unknown.
      for (int i = 0; i < NUM_INT_SRCS; i++) prio_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INT_SRCS; i++) begin
        if (prio_wr[i]) prio_q[i] <= if_mem.w_data[PRIO_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// Bench for prio_interrupt_controller.
// Directed scenarios are followed by a randomized phase. Every read is scored
// against a behavioural model of the register map, and o_int is compared every cycle.
module tb_prio_interrupt_controller;
  localparam int NS = 8;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] irq;
  logic          o_int;

  mem_if bus ();

  prio_interrupt_controller #(.NUM_INT_SRCS(NS), .PRIO_BITS(PB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_int (irq),
    .o_int (o_int),
    .if_mem(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int unsigned want;
    bit          pv;
    int unsigned pval;
    int unsigned addr;
  } rd_item_t;

  rd_item_t    sb_q [$];
  bit          plan_v;
  int unsigned plan_val;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [NS-1:0] m_en, m_pend, m_trig, m_ins, m_intq;
  int          m_thr;
  int          m_prio [NS];

  function automatic bit m_elig(int i);
    return m_en[i] && m_pend[i] && !m_ins[i] && (m_prio[i] > m_thr);
  endfunction

  function automatic bit m_oint();
    for (int i = 0; i < NS; i++) if (m_elig(i)) return 1'b1;
    return 1'b0;
  endfunction

  // Ranking key: priority first, then lower index.
  function automatic int m_claim_id();
    int best = -1;
    int best_key = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_elig(i) && (m_prio[i] * 64 + (63 - i)) > best_key) begin
        best_key = m_prio[i] * 64 + (63 - i);
        best     = i;
      end
    end
    return best + 1;
  endfunction

  function automatic int unsigned m_read(int idx);
    case (idx)
      0: return 32'(m_en);
      1: return 32'(m_pend);
      2: return 32'(m_trig);
      3: return 32'(m_thr);
      4: return 32'(m_claim_id());
      5: return 32'(m_ins);
      default: return (idx >= 16 && idx < 16 + NS) ? 32'(m_prio[idx-16]) : 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int          idx;
    int          cid;
    bit [NS-1:0] clr;
    bit [NS-1:0] old_trig;
    rd_item_t    it;
    if (rst) begin
      m_en = '0; m_pend = '0; m_trig = '0; m_ins = '0; m_intq = '0; m_thr = 0;
      for (int i = 0; i < NS; i++) m_prio[i] = 0;
      return;
    end
    idx      = int'((bus.addr >> 2) & 32'h3f);
    cid      = m_claim_id();
    old_trig = m_trig;
    clr      = '0;
    if (bus.valid && !bus.w_en) begin
      it.want = m_read(idx);
      it.pv   = plan_v;
      it.pval = plan_val;
      it.addr = bus.addr;
      sb_q.push_back(it);
      if (idx == 4 && cid != 0) begin
        m_ins[cid-1] = 1'b1;
        clr[cid-1]   = 1'b1;
      end
    end
    if (bus.valid && bus.w_en) begin
      case (idx)
        0: m_en   = bus.w_data[NS-1:0];
        1: clr    = clr | bus.w_data[NS-1:0];
        2: m_trig = bus.w_data[NS-1:0];
        3: m_thr  = int'(bus.w_data % (1 << PB));
        4: if (bus.w_data >= 1 && bus.w_data <= NS) m_ins[bus.w_data-1] = 1'b0;
        default: if (idx >= 16 && idx < 16 + NS) m_prio[idx-16] = int'(bus.w_data % (1 << PB));
      endcase
    end
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = old_trig[i] ? ((m_pend[i] && !clr[i]) || (irq[i] && !m_intq[i])) : irq[i];
    end
    m_intq = irq;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  bit       took;
  rd_item_t got;
  initial forever begin
    @(posedge clk);
    took = bus.valid && !bus.w_en && !rst;
    @(negedge clk);
    check("o_int", o_int, m_oint());
    if (took) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL scoreboard: read seen, got nothing queued, expected an entry");
      end else begin
        got = sb_q.pop_front();
        check($sformatf("r_data@%0h", got.addr), bus.r_data, got.want);
        if (got.pv) check($sformatf("plan_read@%0h", got.addr), bus.r_data, got.pval);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic beat(input bit we, input int unsigned a, input int unsigned d,
                      input bit pv, input int unsigned pval);
    bus.valid = 1'b1; bus.w_en = we; bus.addr = a; bus.w_data = d;
    plan_v = pv; plan_val = pval;
    @(negedge clk);
    bus.valid = 1'b0; bus.w_en = 1'b0; plan_v = 1'b0;
  endtask

  task automatic wr(input int unsigned a, input int unsigned d);
    beat(1'b1, a, d, 1'b0, 0);
  endtask

  task automatic rd_exp(input int unsigned a, input int unsigned e);
    beat(1'b0, a, 0, 1'b1, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic oint_exp(input bit e, input string nm);
    check(nm, o_int, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq = '1; plan_v = 1'b0; plan_val = 0;
    bus.valid = 1'b0; bus.w_en = 1'b0; bus.addr = '0; bus.w_data = '0;
    idle(2);
    check("reset_r_data", bus.r_data, 32'd0);
    oint_exp(1'b0, "reset_o_int");
    rst = 1'b0;

    // Level, all enabled, priority 0: pending follows lines, nothing claimable.
    wr(32'h00, 32'hFF);
    rd_exp(32'h04, 32'hFF);
    rd_exp(32'h10, 0);
    oint_exp(1'b0, "prio0_o_int");
    irq = '0;
    idle(2);

    // Level sources 2 and 5.
    wr(32'h48, 3); wr(32'h54, 6); wr(32'h0C, 0);
    irq = 8'h24;
    idle(1);
    oint_exp(1'b1, "lvl_o_int");
    rd_exp(32'h10, 6);
    oint_exp(1'b1, "after_claim6");
    rd_exp(32'h10, 3);
    rd_exp(32'h10, 0);
    oint_exp(1'b0, "all_in_service");
    wr(32'h10, 6);
    oint_exp(1'b1, "complete6_relevel");
    irq = '0;
    wr(32'h10, 3);
    wr(32'h48, 0); wr(32'h54, 0);
    idle(1);

    // Equal priority tie, then threshold masking.
    wr(32'h44, 4); wr(32'h5C, 4);
    irq = 8'h82;
    idle(1);
    rd_exp(32'h10, 2);
    wr(32'h0C, 4);
    oint_exp(1'b0, "threshold_mask");
    rd_exp(32'h10, 0);
    wr(32'h10, 2); wr(32'h0C, 0);
    irq = '0;
    wr(32'h44, 0); wr(32'h5C, 0);
    idle(1);

    // Edge source 0, W1C racing a new edge.
    wr(32'h08, 1); wr(32'h40, 1);
    irq[0] = 1'b1; idle(1); irq[0] = 1'b0;
    rd_exp(32'h04, 1);
    idle(1);
    irq[0] = 1'b1; wr(32'h04, 1); irq[0] = 1'b0;
    rd_exp(32'h04, 1);
    wr(32'h04, 1);
    rd_exp(32'h04, 0);

    // Edge source 3 while disabled stays pending.
    wr(32'h00, 32'hF7); wr(32'h08, 32'h09); wr(32'h4C, 2);
    irq[3] = 1'b1; idle(1); irq[3] = 1'b0;
    rd_exp(32'h04, 8);
    oint_exp(1'b0, "disabled_edge");
    wr(32'h00, 32'hFF);
    oint_exp(1'b1, "enabled_edge");
    rd_exp(32'h10, 4);
    wr(32'h10, 4);

    // Reset mid-service, then an out-of-range completion.
    wr(32'h50, 5);
    irq[4] = 1'b1; idle(1);
    rd_exp(32'h10, 5);
    rst = 1'b1; idle(1); rst = 1'b0;
    rd_exp(32'h14, 0);
    rd_exp(32'h00, 0);
    oint_exp(1'b0, "post_reset_o_int");
    wr(32'h50, 5); wr(32'h00, 32'h10);
    rd_exp(32'h10, 5);
    wr(32'h10, 9);
    rd_exp(32'h14, 32'h10);
    oint_exp(1'b0, "id9_ignored");
    wr(32'h10, 5);
    irq = '0;
    idle(2);

    // Randomized phase.
    for (int k = 0; k < 1500; k++) begin
      int unsigned a;
      int unsigned r;
      a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 9);
      if ($urandom_range(0, 2) == 0) irq[$urandom_range(0, NS-1)] ^= 1'b1;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        beat(1'(($urandom_range(0, 1))), a, $urandom, 1'b0, 0);
        rst = 1'b0;
      end else if (r < 35) begin
        beat(1'b0, a, 0, 1'b0, 0);
      end else if (r < 50) begin
        beat(1'b0, 32'h10, 0, 1'b0, 0);
      end else if (r < 62) begin
        wr(32'h10, $urandom_range(0, 10));
      end else if (r < 90) begin
        wr(a, $urandom);
      end else begin
        idle(1);
      end
    end

    idle(3);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
